// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (a - b - bin), LSB first, with valid/ready handshakes.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned   CW       = cnt_w(N);
  localparam logic [CW-1:0] CNT_PEN  = CW'(N - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          brw_q, brw_d;
  logic          msb_bin_q, msb_bin_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic          bit_d;
  logic          bit_bout;

  full_subtractor u_fs (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (brw_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    msb_bin_d = msb_bin_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    res_d     = res_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {bit_d, res_q[N-1:1]};
        brw_d = bit_bout;
        cnt_d = cnt_q + CW'(1);
        // Borrow leaving bit N-2 is the borrow into the MSB, needed for ovf.
        if (cnt_q == CNT_PEN) begin
          msb_bin_d = bit_bout;
        end
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_d;
          bout_d  = bit_bout;
          ovf_d   = msb_bin_q ^ bit_bout;
          zero_d  = (res_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      brw_q     <= 1'b0;
      msb_bin_q <= 1'b0;
      sa_q      <= '0;
      sb_q      <= '0;
      res_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      brw_q     <= brw_d;
      msb_bin_q <= msb_bin_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      res_q     <= res_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                        input int in_dly, input int out_dly);
    logic [N-1:0] ed;
    logic         eb, eo, ez;
    int           s, ua, ub, lat;
    ua = int'(ta);
    ub = int'(tb);
    ed = N'(ua - ub - int'(tbin));
    eb = (ua < ub + int'(tbin));
    s  = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    eo = (s > (2 ** (N - 1)) - 1) || (s < -(2 ** (N - 1)));
    ez = (ed == '0);

    repeat (in_dly) step();
    in_valid = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    lat = 0;
    while (!in_ready && lat < 20) begin
      step();
      lat++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * int'(N)) begin
      a = N'($urandom);
      b = N'($urandom);
      bin = 1'($urandom);
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(N));
    check("in_ready_done", 32'(in_ready), 32'd0);
    check("diff", 32'(diff), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("ovf", 32'(ovf), 32'(eo));
    check("zero", 32'(zero), 32'(ez));

    out_ready = 1'b0;
    for (int i = 0; i < out_dly; i++) begin
      in_valid = 1'($urandom);
      a = N'($urandom);
      b = N'($urandom);
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold", {21'd0, zero, ovf, bout, diff}, {21'd0, ez, eo, eb, ed});
    end
    out_ready = 1'b1;
    in_valid = 1'($urandom);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("post_hold", {21'd0, zero, ovf, bout, diff}, {21'd0, ez, eo, eb, ed});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {21'd0, zero, ovf, bout, diff}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op(8'h05, 8'h03, 1'b0, 0, 0);
    run_op(8'h03, 8'h05, 1'b0, 0, 0);
    run_op(8'h00, 8'h00, 1'b1, 1, 0);
    run_op(8'h80, 8'h01, 1'b0, 0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 0, 0);
    run_op(8'h10, 8'h0F, 1'b1, 0, 5);

    // Abort mid-shift after a result with non-zero flags is on the outputs.
    run_op(8'h03, 8'h05, 1'b0, 0, 0);
    in_valid = 1'b1;
    a = 8'h44;
    b = 8'h11;
    bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_outputs", {21'd0, zero, ovf, bout, diff}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("abort_release_in_ready", 32'(in_ready), 32'd1);
    repeat (N + 2) begin
      step();
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(8'h20, 8'h01, 1'b0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '1;
        2: ra = {1'b1, {(N - 1){1'b0}}};
        3: rb = ra;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
